// File: rtl/if_bpu_pkg.sv
// if_bpu_pkg: shared definitions for the fetch-side branch prediction unit.
//   - RISC-V opcodes the predictor decodes (conditional branch, JAL)
//   - 2-bit saturating counter encoding used by the BHT
//   - bht_next(): saturating counter update
package if_bpu_pkg;

   localparam logic [6:0] INSTR_BXX = 7'b1100011;
   localparam logic [6:0] INSTR_JAL = 7'b1101111;

   // Bit 1 of the counter is the taken prediction.
   typedef enum logic [1:0] {
      BHT_SNT = 2'b00,   // strongly not-taken
      BHT_WNT = 2'b01,   // weakly not-taken (reset value)
      BHT_WT  = 2'b10,   // weakly taken
      BHT_ST  = 2'b11    // strongly taken
   } bht_cnt_e;

   // Move one step toward the observed outcome, saturating at both ends.
   function automatic bht_cnt_e bht_next(input bht_cnt_e cnt, input logic taken);
      bht_cnt_e nxt;
      case (cnt)
         BHT_SNT: nxt = taken ? BHT_WNT : BHT_SNT;
         BHT_WNT: nxt = taken ? BHT_WT  : BHT_SNT;
         BHT_WT:  nxt = taken ? BHT_ST  : BHT_WNT;
         default: nxt = taken ? BHT_ST  : BHT_WT;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/if_bpu_if.sv
// if_bpu_if: bus between IF / EX and the branch prediction unit.
//   prdt_*   : IF presents a fetched instruction, BPU answers combinationally
//   upd_*    : EX reports a resolved control-flow instruction
//   flush_o / redirect_pc_o : BPU tells IF to squash and restart fetch
// Handshake: there is no ready on either channel. A channel carries a
// transaction in every cycle its valid is high at the rising clock edge; the
// BPU always accepts (updates are only ignored as wrong-path while flush_o=1).
// modport master = IF/EX side, modport slave = BPU side.
interface if_bpu_if #(
   parameter int XLEN = 32
);
   logic            prdt_valid_i;
   logic [XLEN-1:0] prdt_pc_i;
   logic [31:0]     prdt_instr_i;
   logic            prdt_taken_o;
   logic [XLEN-1:0] prdt_target_o;
   logic            upd_valid_i;
   logic            upd_is_bxx_i;
   logic [XLEN-1:0] upd_pc_i;
   logic            upd_taken_i;
   logic            upd_prdt_taken_i;
   logic [XLEN-1:0] upd_target_i;
   logic            flush_o;
   logic [XLEN-1:0] redirect_pc_o;

   modport master (
      output prdt_valid_i, prdt_pc_i, prdt_instr_i,
      output upd_valid_i, upd_is_bxx_i, upd_pc_i, upd_taken_i, upd_prdt_taken_i, upd_target_i,
      input  prdt_taken_o, prdt_target_o, flush_o, redirect_pc_o
   );

   modport slave (
      input  prdt_valid_i, prdt_pc_i, prdt_instr_i,
      input  upd_valid_i, upd_is_bxx_i, upd_pc_i, upd_taken_i, upd_prdt_taken_i, upd_target_i,
      output prdt_taken_o, prdt_target_o, flush_o, redirect_pc_o
   );
endinterface

// File: rtl/if_bpu_bht.sv
// if_bpu_bht: branch history table of 2-bit saturating counters.
//   clk, rst_n  : clock, asynchronous active-low reset (all counters -> WNT)
//   rd_idx      : combinational read index
//   rd_taken    : counter MSB at rd_idx (pre-update value, no write bypass)
//   wr_en       : apply one saturating step at the next rising edge
//   wr_idx      : counter to train
//   wr_taken    : direction of the step
module if_bpu_bht
   import if_bpu_pkg::*;
#(
   parameter int ENTRIES = 64,
   parameter int IDX_W   = $clog2(ENTRIES)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] rd_idx,
   output logic             rd_taken,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic             wr_taken
);

   bht_cnt_e cnt_q [ENTRIES];

   assign rd_taken = cnt_q[rd_idx][1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            cnt_q[i] <= BHT_WNT;
         end
      end else if (wr_en) begin
         cnt_q[wr_idx] <= bht_next(cnt_q[wr_idx], wr_taken);
      end
   end

endmodule

// File: rtl/if_bpu.sv
// if_bpu: fetch-side branch prediction unit.
//   clk, rst_n : core clock, asynchronous active-low reset
//   bus        : if_bpu_if slave modport
//     prediction : prdt_valid_i/pc/instr in -> prdt_taken_o/prdt_target_o,
//                  combinational, zero when prdt_valid_i=0
//     update     : upd_* from EX trains the BHT on conditional branches
//     redirect   : flush_o one-cycle pulse with redirect_pc_o the cycle
//                  after a mispredict; redirect_pc_o holds otherwise
module if_bpu
   import if_bpu_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int BHT_ENTRIES = 64
) (
   input logic     clk,
   input logic     rst_n,
   if_bpu_if.slave bus
);

   localparam int IDX_W = $clog2(BHT_ENTRIES);

   logic            bht_taken;
   logic            upd_ok;
   logic            mis;
   logic            flush_q;
   logic [XLEN-1:0] redirect_q;
   logic [XLEN-1:0] b_imm;
   logic [XLEN-1:0] j_imm;
   logic [6:0]      opcode;

   // An update seen while the flush pulse is out belongs to the squashed
   // path, so it neither trains the table nor raises another flush.
   assign upd_ok = bus.upd_valid_i & ~flush_q;
   assign mis    = upd_ok & (bus.upd_taken_i != bus.upd_prdt_taken_i);

   if_bpu_bht #(
      .ENTRIES (BHT_ENTRIES),
      .IDX_W   (IDX_W)
   ) u_bht (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_idx   (bus.prdt_pc_i[IDX_W+1:2]),
      .rd_taken (bht_taken),
      .wr_en    (upd_ok & bus.upd_is_bxx_i),
      .wr_idx   (bus.upd_pc_i[IDX_W+1:2]),
      .wr_taken (bus.upd_taken_i)
   );

   // Sign-extended B-type and J-type immediates (bit 0 is always zero).
   assign opcode = bus.prdt_instr_i[6:0];
   assign b_imm  = {{(XLEN-12){bus.prdt_instr_i[31]}}, bus.prdt_instr_i[7],
                    bus.prdt_instr_i[30:25], bus.prdt_instr_i[11:8], 1'b0};
   assign j_imm  = {{(XLEN-20){bus.prdt_instr_i[31]}}, bus.prdt_instr_i[19:12],
                    bus.prdt_instr_i[20], bus.prdt_instr_i[30:21], 1'b0};

   // Target sums wrap modulo 2^XLEN by construction.
   always_comb begin
      bus.prdt_taken_o  = 1'b0;
      bus.prdt_target_o = '0;
      if (bus.prdt_valid_i) begin
         case (opcode)
            INSTR_BXX: begin
               bus.prdt_taken_o  = bht_taken;
               bus.prdt_target_o = bus.prdt_pc_i + b_imm;
            end
            INSTR_JAL: begin
               bus.prdt_taken_o  = 1'b1;
               bus.prdt_target_o = bus.prdt_pc_i + j_imm;
            end
            default: begin
               bus.prdt_target_o = bus.prdt_pc_i + XLEN'(4);
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flush_q    <= 1'b0;
         redirect_q <= '0;
      end else begin
         flush_q <= mis;
         if (mis) begin
            redirect_q <= bus.upd_taken_i ? bus.upd_target_i : bus.upd_pc_i + XLEN'(4);
         end
      end
   end

   assign bus.flush_o       = flush_q;
   assign bus.redirect_pc_o = redirect_q;

endmodule

// File: tb/tb_if_bpu.sv
// tb_if_bpu: directed bench for if_bpu. Inputs change on the falling edge;
// combinational outputs are sampled 1 time unit later, registered outputs on
// the falling edge after the capturing rising edge.
module tb_if_bpu;

   localparam int XLEN = 32;
   localparam logic [31:0] I_BEQ_P16 = 32'h0000_0863;  // beq x0,x0,+16
   localparam logic [31:0] I_BNE_M4  = 32'hFE00_1EE3;  // bne x0,x0,-4
   localparam logic [31:0] I_JAL_M8  = 32'hFF9F_F06F;  // jal x0,-8
   localparam logic [31:0] I_JALR    = 32'h0000_8067;  // jalr x0,0(x1)

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   if_bpu_if #(.XLEN(XLEN)) bus ();

   if_bpu #(.XLEN(XLEN), .BHT_ENTRIES(64)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      bus.prdt_valid_i     = 1'b0;
      bus.prdt_pc_i        = '0;
      bus.prdt_instr_i     = '0;
      bus.upd_valid_i      = 1'b0;
      bus.upd_is_bxx_i     = 1'b0;
      bus.upd_pc_i         = '0;
      bus.upd_taken_i      = 1'b0;
      bus.upd_prdt_taken_i = 1'b0;
      bus.upd_target_i     = '0;
   endtask

   // Present a fetch on the next falling edge and settle.
   task automatic drive_pred(input logic valid, input logic [31:0] pc, input logic [31:0] instr);
      @(negedge clk);
      bus.prdt_valid_i = valid;
      bus.prdt_pc_i    = pc;
      bus.prdt_instr_i = instr;
      #1;
   endtask

   // Hold one update across a single rising edge; returns on the following
   // falling edge, where the registered flush for it is visible.
   task automatic drive_upd(input logic [31:0] pc, input logic is_bxx, input logic taken,
                            input logic prdt, input logic [31:0] target);
      @(negedge clk);
      bus.upd_valid_i      = 1'b1;
      bus.upd_is_bxx_i     = is_bxx;
      bus.upd_pc_i         = pc;
      bus.upd_taken_i      = taken;
      bus.upd_prdt_taken_i = prdt;
      bus.upd_target_i     = target;
      @(negedge clk);
      bus.upd_valid_i      = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL reset_flush got %0b want 0", bus.flush_o); end
      checks++; if (bus.redirect_pc_o !== 32'h0) begin errors++; $display("FAIL reset_redirect got %h want 0", bus.redirect_pc_o); end
      rst_n = 1'b1;
      drive_pred(1'b1, 32'h100, I_BEQ_P16);
      checks++; if (bus.prdt_taken_o !== 1'b0) begin errors++; $display("FAIL reset_beq_taken got %0b want 0", bus.prdt_taken_o); end
      checks++; if (bus.prdt_target_o !== 32'h110) begin errors++; $display("FAIL reset_beq_target got %h want 110", bus.prdt_target_o); end
   endtask

   task automatic test_train();
      drive_upd(32'h100, 1'b1, 1'b1, 1'b1, 32'h110);   // WNT -> WT
      drive_pred(1'b1, 32'h100, I_BEQ_P16);
      checks++; if (bus.prdt_taken_o !== 1'b1) begin errors++; $display("FAIL train_1taken got %0b want 1", bus.prdt_taken_o); end
      drive_upd(32'h100, 1'b1, 1'b1, 1'b1, 32'h110);   // WT -> ST
      drive_pred(1'b1, 32'h100, I_BEQ_P16);
      checks++; if (bus.prdt_taken_o !== 1'b1) begin errors++; $display("FAIL train_2taken got %0b want 1", bus.prdt_taken_o); end
      checks++; if (bus.prdt_target_o !== 32'h110) begin errors++; $display("FAIL train_target got %h want 110", bus.prdt_target_o); end
      drive_upd(32'h100, 1'b1, 1'b1, 1'b1, 32'h110);   // stays ST
      drive_upd(32'h100, 1'b1, 1'b1, 1'b1, 32'h110);   // stays ST
      drive_pred(1'b1, 32'h100, I_BEQ_P16);
      checks++; if (bus.prdt_taken_o !== 1'b1) begin errors++; $display("FAIL train_sat_hi got %0b want 1", bus.prdt_taken_o); end
      drive_upd(32'h100, 1'b1, 1'b0, 1'b0, 32'h110);   // ST -> WT
      drive_pred(1'b1, 32'h100, I_BEQ_P16);
      checks++; if (bus.prdt_taken_o !== 1'b1) begin errors++; $display("FAIL train_st_to_wt got %0b want 1", bus.prdt_taken_o); end
      drive_upd(32'h100, 1'b1, 1'b0, 1'b0, 32'h110);   // WT -> WNT
      drive_pred(1'b1, 32'h100, I_BEQ_P16);
      checks++; if (bus.prdt_taken_o !== 1'b0) begin errors++; $display("FAIL train_wt_to_wnt got %0b want 0", bus.prdt_taken_o); end
      drive_upd(32'h100, 1'b0, 1'b1, 1'b1, 32'h200);   // non-BXX: no training
      drive_pred(1'b1, 32'h100, I_BEQ_P16);
      checks++; if (bus.prdt_taken_o !== 1'b0) begin errors++; $display("FAIL train_non_bxx got %0b want 0", bus.prdt_taken_o); end
      checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL train_no_flush got %0b want 0", bus.flush_o); end
   endtask

   task automatic test_same_cycle();
      // idx of 0x100 holds WNT; predict and train it in the same cycle.
      @(negedge clk);
      bus.prdt_valid_i     = 1'b1;
      bus.prdt_pc_i        = 32'h100;
      bus.prdt_instr_i     = I_BEQ_P16;
      bus.upd_valid_i      = 1'b1;
      bus.upd_is_bxx_i     = 1'b1;
      bus.upd_pc_i         = 32'h100;
      bus.upd_taken_i      = 1'b1;
      bus.upd_prdt_taken_i = 1'b1;
      bus.upd_target_i     = 32'h110;
      #1;
      checks++; if (bus.prdt_taken_o !== 1'b0) begin errors++; $display("FAIL same_cycle_old got %0b want 0", bus.prdt_taken_o); end
      @(negedge clk);
      bus.upd_valid_i = 1'b0;
      #1;
      checks++; if (bus.prdt_taken_o !== 1'b1) begin errors++; $display("FAIL same_cycle_new got %0b want 1", bus.prdt_taken_o); end
   endtask

   task automatic test_decode();
      drive_pred(1'b1, 32'h200, I_JAL_M8);
      checks++; if (bus.prdt_taken_o !== 1'b1) begin errors++; $display("FAIL jal_taken got %0b want 1", bus.prdt_taken_o); end
      checks++; if (bus.prdt_target_o !== 32'h1F8) begin errors++; $display("FAIL jal_target got %h want 1f8", bus.prdt_target_o); end
      drive_pred(1'b1, 32'h204, I_JALR);
      checks++; if (bus.prdt_taken_o !== 1'b0) begin errors++; $display("FAIL jalr_taken got %0b want 0", bus.prdt_taken_o); end
      checks++; if (bus.prdt_target_o !== 32'h208) begin errors++; $display("FAIL jalr_target got %h want 208", bus.prdt_target_o); end
      drive_pred(1'b1, 32'h80, I_BNE_M4);
      checks++; if (bus.prdt_taken_o !== 1'b0) begin errors++; $display("FAIL bne_taken got %0b want 0", bus.prdt_taken_o); end
      checks++; if (bus.prdt_target_o !== 32'h7C) begin errors++; $display("FAIL bne_neg_target got %h want 7c", bus.prdt_target_o); end
      drive_pred(1'b1, 32'hFFFF_FFF8, I_BEQ_P16);
      checks++; if (bus.prdt_target_o !== 32'h8) begin errors++; $display("FAIL wrap_target got %h want 8", bus.prdt_target_o); end
      drive_pred(1'b0, 32'h200, I_JAL_M8);
      checks++; if (bus.prdt_taken_o !== 1'b0) begin errors++; $display("FAIL novalid_taken got %0b want 0", bus.prdt_taken_o); end
      checks++; if (bus.prdt_target_o !== 32'h0) begin errors++; $display("FAIL novalid_target got %h want 0", bus.prdt_target_o); end
   endtask

   task automatic test_mispredict();
      drive_upd(32'h300, 1'b0, 1'b1, 1'b0, 32'h400);
      checks++; if (bus.flush_o !== 1'b1) begin errors++; $display("FAIL mis_flush got %0b want 1", bus.flush_o); end
      checks++; if (bus.redirect_pc_o !== 32'h400) begin errors++; $display("FAIL mis_redirect got %h want 400", bus.redirect_pc_o); end
      @(negedge clk);
      checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL mis_pulse_end got %0b want 0", bus.flush_o); end
      checks++; if (bus.redirect_pc_o !== 32'h400) begin errors++; $display("FAIL mis_redirect_hold got %h want 400", bus.redirect_pc_o); end
      drive_upd(32'h340, 1'b1, 1'b0, 1'b1, 32'h999);   // predicted taken, fell through
      checks++; if (bus.flush_o !== 1'b1) begin errors++; $display("FAIL mis_nt_flush got %0b want 1", bus.flush_o); end
      checks++; if (bus.redirect_pc_o !== 32'h344) begin errors++; $display("FAIL mis_nt_redirect got %h want 344", bus.redirect_pc_o); end
      @(negedge clk);
      checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL mis_nt_pulse_end got %0b want 0", bus.flush_o); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      bus.upd_valid_i      = 1'b1;
      bus.upd_is_bxx_i     = 1'b1;
      bus.upd_pc_i         = 32'h508;
      bus.upd_taken_i      = 1'b1;
      bus.upd_prdt_taken_i = 1'b0;
      bus.upd_target_i     = 32'h600;
      @(negedge clk);
      checks++; if (bus.flush_o !== 1'b1) begin errors++; $display("FAIL b2b_first_flush got %0b want 1", bus.flush_o); end
      checks++; if (bus.redirect_pc_o !== 32'h600) begin errors++; $display("FAIL b2b_first_redirect got %h want 600", bus.redirect_pc_o); end
      bus.upd_pc_i     = 32'h50C;
      bus.upd_target_i = 32'h700;
      @(negedge clk);
      bus.upd_valid_i = 1'b0;
      checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL b2b_second_flush got %0b want 0", bus.flush_o); end
      checks++; if (bus.redirect_pc_o !== 32'h600) begin errors++; $display("FAIL b2b_second_redirect got %h want 600", bus.redirect_pc_o); end
      drive_pred(1'b1, 32'h50C, I_BEQ_P16);
      checks++; if (bus.prdt_taken_o !== 1'b0) begin errors++; $display("FAIL b2b_second_no_train got %0b want 0", bus.prdt_taken_o); end
      drive_pred(1'b1, 32'h508, I_BEQ_P16);
      checks++; if (bus.prdt_taken_o !== 1'b1) begin errors++; $display("FAIL b2b_first_trained got %0b want 1", bus.prdt_taken_o); end
   endtask

   task automatic test_reset_flush();
      drive_upd(32'h600, 1'b0, 1'b1, 1'b0, 32'h900);
      checks++; if (bus.flush_o !== 1'b1) begin errors++; $display("FAIL rstf_pending got %0b want 1", bus.flush_o); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL rstf_flush_async got %0b want 0", bus.flush_o); end
      checks++; if (bus.redirect_pc_o !== 32'h0) begin errors++; $display("FAIL rstf_redirect_async got %h want 0", bus.redirect_pc_o); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      drive_pred(1'b1, 32'h508, I_BEQ_P16);
      checks++; if (bus.prdt_taken_o !== 1'b0) begin errors++; $display("FAIL rstf_cnt508 got %0b want 0", bus.prdt_taken_o); end
      checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL rstf_flush_lost got %0b want 0", bus.flush_o); end
      drive_pred(1'b1, 32'h100, I_BEQ_P16);
      checks++; if (bus.prdt_taken_o !== 1'b0) begin errors++; $display("FAIL rstf_cnt100 got %0b want 0", bus.prdt_taken_o); end
      // A single taken step from weakly not-taken must flip the prediction.
      drive_upd(32'h508, 1'b1, 1'b1, 1'b1, 32'h518);
      drive_pred(1'b1, 32'h508, I_BEQ_P16);
      checks++; if (bus.prdt_taken_o !== 1'b1) begin errors++; $display("FAIL rstf_wnt_step got %0b want 1", bus.prdt_taken_o); end
   endtask

   initial begin
      test_reset();
      test_train();
      test_same_cycle();
      test_decode();
      test_mispredict();
      test_back_to_back();
      test_reset_flush();
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
